// File: rtl/raptor64_operand_stage_if.sv
// Operand-stage bundle: decode side, register-file ports, X/M/W forwarding
// inputs and the registered execute-side outputs.
interface raptor64_operand_stage_if #(
  parameter int WID = 64,
  parameter int IRW = 42
);
  logic [IRW-1:0] dIR;
  logic           d_valid;
  logic           d_stall;
  logic [4:0]     rfa_sel;
  logic [4:0]     rfb_sel;
  logic [WID-1:0] rfoa;
  logic [WID-1:0] rfob;
  logic [4:0]     x_tgt;
  logic [4:0]     m_tgt;
  logic [4:0]     w_tgt;
  logic [WID-1:0] x_res;
  logic [WID-1:0] m_res;
  logic [WID-1:0] w_res;
  logic           x_wr;
  logic           m_wr;
  logic           w_wr;
  logic           x_is_load;
  logic           x_stall;
  logic           flush;
  logic [IRW-1:0] xIR;
  logic [WID-1:0] a;
  logic [WID-1:0] b;
  logic [WID-1:0] imm;
  logic           x_valid;

  // slave: the operand stage itself; master: the surrounding pipeline
  modport slave (
    input  dIR, d_valid, rfoa, rfob, x_tgt, m_tgt, w_tgt, x_res, m_res, w_res,
           x_wr, m_wr, w_wr, x_is_load, x_stall, flush,
    output d_stall, rfa_sel, rfb_sel, xIR, a, b, imm, x_valid
  );

  modport master (
    output dIR, d_valid, rfoa, rfob, x_tgt, m_tgt, w_tgt, x_res, m_res, w_res,
           x_wr, m_wr, w_wr, x_is_load, x_stall, flush,
    input  d_stall, rfa_sel, rfb_sel, xIR, a, b, imm, x_valid
  );
endinterface

// File: rtl/raptor64_operand_stage.sv
// Register-read / operand stage: forwarding muxes, IMM-prefix immediate
// assembly, load-use hazard detection and the execute-stage input registers.
module raptor64_operand_stage #(
  parameter int             WID    = 64,
  parameter int             IRW    = 42,
  parameter logic [IRW-1:0] NOP_IR = '0,
  parameter logic [6:0]     IMM_OP = 7'h70
) (
  input logic clk_i,
  input logic rst_i,
  raptor64_operand_stage_if.slave bus
);
  localparam int PW = WID - 25;

  logic [6:0]     opcode;
  logic           is_imm;
  logic           haz;
  logic [WID-1:0] imm_next;

  logic [IRW-1:0] xir_reg;
  logic [WID-1:0] a_reg;
  logic [WID-1:0] b_reg;
  logic [WID-1:0] imm_reg;
  logic           x_valid_reg;
  logic [PW-1:0]  pfx_reg;
  logic           pfx_valid_reg;

  assign opcode = bus.dIR[41:35];
  assign is_imm = (opcode == IMM_OP);

  // Port 0 reads Ra, port 1 reads Rb; X results from a load are not ready yet.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [4:0]     sel;
    logic [WID-1:0] rf_data;
    logic [WID-1:0] val;
    logic           hit_x;

    assign sel     = (gi == 0) ? bus.dIR[34:30] : bus.dIR[29:25];
    assign rf_data = (gi == 0) ? bus.rfoa : bus.rfob;
    assign hit_x   = (bus.x_tgt == sel);

    always_comb begin
      val = rf_data;
      if (sel == 5'd0)
        val = '0;
      else if (bus.x_wr && hit_x && !bus.x_is_load)
        val = bus.x_res;
      else if (bus.m_wr && bus.m_tgt == sel)
        val = bus.m_res;
      else if (bus.w_wr && bus.w_tgt == sel)
        val = bus.w_res;
    end
  end

  assign haz = bus.d_valid && bus.x_wr && bus.x_is_load && (bus.x_tgt != 5'd0) &&
               (g_port[0].hit_x || g_port[1].hit_x);

  assign imm_next = pfx_valid_reg ? {pfx_reg, bus.dIR[24:0]}
                                  : {{PW{bus.dIR[24]}}, bus.dIR[24:0]};

  assign bus.d_stall = rst_i && (bus.x_stall || haz);
  assign bus.rfa_sel = bus.dIR[34:30];
  assign bus.rfb_sel = bus.dIR[29:25];
  assign bus.xIR     = xir_reg;
  assign bus.a       = a_reg;
  assign bus.b       = b_reg;
  assign bus.imm     = imm_reg;
  assign bus.x_valid = x_valid_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      xir_reg       <= NOP_IR;
      a_reg         <= '0;
      b_reg         <= '0;
      imm_reg       <= '0;
      x_valid_reg   <= 1'b0;
      pfx_reg       <= '0;
      pfx_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      xir_reg       <= NOP_IR;
      x_valid_reg   <= 1'b0;
      pfx_valid_reg <= 1'b0;
    end else if (bus.x_stall) begin
      xir_reg       <= xir_reg;
      x_valid_reg   <= x_valid_reg;
    end else if (haz) begin
      xir_reg       <= NOP_IR;
      x_valid_reg   <= 1'b0;
    end else if (bus.d_valid && is_imm) begin
      // Prefix overlaps the low opcode bits; the last prefix seen wins.
      xir_reg       <= NOP_IR;
      x_valid_reg   <= 1'b0;
      pfx_reg       <= bus.dIR[PW-1:0];
      pfx_valid_reg <= 1'b1;
    end else if (bus.d_valid) begin
      xir_reg       <= bus.dIR;
      a_reg         <= g_port[0].val;
      b_reg         <= g_port[1].val;
      imm_reg       <= imm_next;
      x_valid_reg   <= 1'b1;
      pfx_valid_reg <= 1'b0;
    end else begin
      xir_reg       <= NOP_IR;
      x_valid_reg   <= 1'b0;
    end
  end
endmodule

// File: doc/raptor64_operand_stage.md
Name: raptor64_operand_stage

Overview:
Register-read/operand stage that sits directly upstream of the execute-stage datapath units (logic, add/sub, shift). It captures the decoded instruction, reads operands from the register-file read ports, and forwards results from the X, M and W stages. It assembles the 64-bit immediate, including IMM-prefix extension, and registers the xIR, a, b and imm consumed by execute. It also detects load-use hazards and stalls decode.

Parameters:
WID, 64, datapath width
IRW, 42, instruction width
NOP_IR, 42'h0, xIR value driven when the stage holds a bubble

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-low reset
dIR  in  42  instruction from decode
d_valid  in  1  dIR valid
d_stall  out  1  decode must hold dIR (load-use bubble or downstream stall)
rfa_sel  out  5  regfile read port A address = dIR[34:30]
rfb_sel  out  5  regfile read port B address = dIR[29:25]
rfoa  in  64  regfile port A data (combinational, same cycle)
rfob  in  64  regfile port B data
x_tgt, m_tgt, w_tgt  in  5 each  destination register of X/M/W stage
x_res, m_res, w_res  in  64 each  result of X/M/W stage
x_wr, m_wr, w_wr  in  1 each  stage will write its target
x_is_load  in  1  instruction in X is a load (result not yet available)
x_stall  in  1  execute cannot accept a new instruction this cycle
flush  in  1  branch/exception flush
xIR  out  42  registered instruction to execute
a, b  out  64 each  registered operands
imm  out  64  registered immediate
x_valid  out  1  xIR/a/b/imm valid

Behaviour:
- Reset (rst_i=0, asynchronous): x_valid=0, xIR=NOP_IR, a=b=imm=0, prefix valid=0, prefix=0. d_stall is combinational and reads 0 under reset.
- Operand selection, per port (combinational from dIR):
  - reg==0 gives 0; r0 is never forwarded.
  - Otherwise priority: X match (x_wr and x_tgt==reg and not x_is_load), then M match, then W match, then rfoa/rfob.
- Hazard: haz = d_valid and x_wr and x_is_load and x_tgt!=0 and x_tgt equals Ra or Rb.
- d_stall = x_stall or haz.
- Immediate:
  - Opcode `IMM (dIR[41:35]) is a prefix. It latches dIR[38:0] into the prefix register, sets prefix valid and produces no execute instruction.
  - Other instructions: imm = {prefix[38:0], dIR[24:0]} if prefix valid, else sign-extended dIR[24:0].
  - Prefix valid clears when an instruction consuming it advances.
  - The prefix is held if that instruction stalls.
- Advance, each edge, in priority order:
  1. flush: x_valid=0, xIR=NOP_IR, prefix valid=0.
  2. x_stall: all output registers hold.
  3. haz: insert bubble (x_valid=0, xIR=NOP_IR). The prefix is kept and decode holds.
  4. d_valid and not IMM: load xIR=dIR, a, b, imm, x_valid=1.
  5. Otherwise: x_valid=0, xIR=NOP_IR.
- Latency: one cycle from dIR accepted to xIR/a/b/imm.
- Forwarding uses the current-cycle X/M/W values, so a result produced in X this cycle reaches the next instruction without a bubble. Loads are the exception and need exactly one bubble.
- Simultaneous cases:
  - flush together with x_stall: flush wins.
  - Back-to-back IMM prefixes: the last prefix wins.
  - flush between a prefix and its consumer discards the prefix.
- Reset mid-operation: immediately returns all state to reset values; no partial instruction survives.

Test Plan:
- Reset with d_valid=1 -> x_valid=0, xIR=0, a=b=imm=0. After release, first dIR (ANDI r1,r2,#-1; rfoa=64'h5) -> next cycle a=5, imm=64'hFFFF_FFFF_FFFF_FFFF, x_valid=1.
- RR with Ra=3, Rb=3; x_tgt=3, x_res=A, m_tgt=3, m_res=B, x_wr=m_wr=1 -> a=b=A. With x_wr=0 -> a=b=B. With Ra=0 -> a=0 despite all matches.
- Load in X targeting r4, next instruction reads r4 -> d_stall=1 for one cycle, x_valid=0 bubble. The following cycle a takes m_res.
- IMM prefix dIR[38:0]=39'h1 then ORI imm field 25'h0000010 -> imm=64'h0000_0000_0200_0010. The prefix is consumed, so the next ORI sign-extends normally.
- x_stall=1 for 3 cycles with new dIR -> outputs hold and d_stall=1. Release -> the new instruction loads once, with no duplicate and no loss.
- flush asserted during x_stall with a pending prefix -> next cycle x_valid=0, xIR=NOP_IR, and the following instruction's imm is sign-extended only.
